// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the multdiv issue sequencer.
//   md_op_e     - multiply/divide operator encoding understood by the multdiv datapath
//   issue_fsm_e - sequencer states: idle, operation in flight, draining a killed op, result held
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL,
        MD_OP_MULH,
        MD_OP_DIV,
        MD_OP_REM
    } md_op_e;

    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_BUSY,
        ISS_DRAIN,
        ISS_RESP
    } issue_fsm_e;

endpackage

// File: rtl/ibex_multdiv_issue.sv
// ibex_multdiv_issue: issues one multiply/divide at a time to the multdiv datapath and returns its result.
//   req_*          - decoded request in (valid/ready), latched on accept
//   flush_i        - kills the current operation; an in-flight op is drained, not abandoned
//   md_*           - enables, operator, signed mode and operands to multdiv, held for the whole op
//   md_valid_i/md_result_i - completion from multdiv; result captured on the valid cycle
//   rsp_*          - registered result and tag out (valid/ready)
//   err_o          - one-cycle pulse when the responder exceeds TimeoutCycles in BUSY/DRAIN
module ibex_multdiv_issue
    import ibex_pkg::*;
#(
    parameter int unsigned TagW          = 5,
    parameter int unsigned TimeoutCycles = 63
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  md_op_e          req_op_i,
    input  logic [1:0]      req_signed_i,
    input  logic [31:0]     req_a_i,
    input  logic [31:0]     req_b_i,
    input  logic [TagW-1:0] req_tag_i,
    input  logic            flush_i,
    output logic            md_mult_en_o,
    output logic            md_div_en_o,
    output md_op_e          md_operator_o,
    output logic [1:0]      md_signed_mode_o,
    output logic [31:0]     md_op_a_o,
    output logic [31:0]     md_op_b_o,
    input  logic            md_valid_i,
    input  logic [31:0]     md_result_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [31:0]     rsp_result_o,
    output logic [TagW-1:0] rsp_tag_o,
    output logic            err_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    issue_fsm_e      state_q;
    md_op_e          op_q;
    logic [1:0]      signed_q;
    logic [31:0]     a_q, b_q, result_q;
    logic [TagW-1:0] tag_q;
    logic [CntW-1:0] cnt_q;
    logic            err_q;
    logic            active, accept, timeout, is_mul;

    // Enables must stay high through DRAIN so the responder's FSMs run to completion.
    assign active  = state_q == ISS_BUSY || state_q == ISS_DRAIN;
    assign is_mul  = op_q == MD_OP_MULL || op_q == MD_OP_MULH;
    assign req_ready_o = !flush_i && (state_q == ISS_IDLE || (state_q == ISS_RESP && rsp_ready_i));
    assign accept  = req_valid_i && req_ready_o;
    // The counter reads TimeoutCycles-1 on the TimeoutCycles-th BUSY/DRAIN cycle.
    assign timeout = active && cnt_q == CntW'(TimeoutCycles - 1);

    assign md_mult_en_o     = active && is_mul;
    assign md_div_en_o      = active && !is_mul;
    assign md_operator_o    = op_q;
    assign md_signed_mode_o = signed_q;
    assign md_op_a_o        = a_q;
    assign md_op_b_o        = b_q;
    assign rsp_valid_o      = state_q == ISS_RESP && !flush_i;
    assign rsp_result_o     = result_q;
    assign rsp_tag_o        = tag_q;
    assign err_o            = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ISS_IDLE;
            op_q     <= MD_OP_MULL;
            signed_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                op_q     <= req_op_i;
                signed_q <= req_signed_i;
                a_q      <= req_a_i;
                b_q      <= req_b_i;
                tag_q    <= req_tag_i;
                cnt_q    <= '0;
            end else if (active) begin
                cnt_q <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
            case (state_q)
                ISS_IDLE: if (accept) state_q <= ISS_BUSY;
                ISS_BUSY: begin
                    if (timeout) begin
                        state_q <= ISS_IDLE;
                        err_q   <= 1'b1;
                    end else if (md_valid_i && flush_i) begin
                        state_q <= ISS_IDLE;
                    end else if (md_valid_i) begin
                        result_q <= md_result_i;
                        state_q  <= ISS_RESP;
                    end else if (flush_i) begin
                        state_q <= ISS_DRAIN;
                    end
                end
                ISS_DRAIN: begin
                    if (timeout) begin
                        state_q <= ISS_IDLE;
                        err_q   <= 1'b1;
                    end else if (md_valid_i) begin
                        state_q <= ISS_IDLE;
                    end
                end
                ISS_RESP: begin
                    if (flush_i) state_q <= ISS_IDLE;
                    else if (rsp_ready_i) state_q <= accept ? ISS_BUSY : ISS_IDLE;
                end
                default: state_q <= ISS_IDLE;
            endcase
        end
    end

    // A completion with nothing in flight means the responder and sequencer disagree.
    a_valid_in_flight: assert property (@(posedge clk_i) disable iff (!rst_ni)
        md_valid_i |-> active);

endmodule

// File: doc/ibex_multdiv_issue.md
Name: ibex_multdiv_issue

Overview:
- Initiator-side sequencer that issues multiply/divide operations to the multdiv datapath (fast or slow variant) and collects their results.
- Accepts decoded requests over a valid/ready handshake and drives mult_en/div_en, operator, signed mode and operands, holding them stable for the whole operation.
- Registers the result and returns it with its tag over a valid/ready response channel.
- Handles pipeline flush, including draining an operation already in flight, and runs a watchdog on the responder.

Parameters:
- TagW, 5, width of the request/response tag (destination register index).
- TimeoutCycles, 63, maximum cycles in BUSY/DRAIN before the watchdog fires; must be at least 40.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when valid&ready
- req_op_i  input  md_op_e  MD_OP_MULL/MULH/DIV/REM
- req_signed_i  input  2  signed_mode; bit0 = op A signed, bit1 = op B signed
- req_a_i  input  32  operand A
- req_b_i  input  32  operand B
- req_tag_i  input  TagW  opaque tag
- flush_i  input  1  kill the current operation
- md_mult_en_o  output  1  to multdiv mult_en_i
- md_div_en_o  output  1  to multdiv div_en_i
- md_operator_o  output  md_op_e  to multdiv operator_i
- md_signed_mode_o  output  2  to multdiv signed_mode_i
- md_op_a_o  output  32  to multdiv op_a_i
- md_op_b_o  output  32  to multdiv op_b_i
- md_valid_i  input  1  from multdiv valid_o
- md_result_i  input  32  from multdiv multdiv_result_o
- rsp_valid_o  output  1  result valid
- rsp_ready_i  input  1  consumer accepts the result
- rsp_result_o  output  32  result
- rsp_tag_o  output  TagW  tag of the result
- err_o  output  1  one-cycle pulse on watchdog timeout

Behaviour:
- Reset (rst_ni asynchronous, active-low; clock clk_i): state IDLE, all md_* and rsp_* outputs 0, err_o 0, operand/tag/result registers 0.
- States:
  - IDLE: req_ready_o = !flush_i. On accept, latch op, signed, a, b and tag; next state BUSY.
  - BUSY: md_mult_en_o = (op is MULL or MULH); md_div_en_o = (op is DIV or REM). md_* operand fields come from the latched registers only, never combinationally from req_*. Enables stay held every cycle until md_valid_i.
    - md_valid_i: capture md_result_i in that same cycle (the multiplier result is combinational on the valid cycle); next state RESP.
    - flush_i without md_valid_i: next state DRAIN.
    - flush_i together with md_valid_i: discard the result; next state IDLE.
  - DRAIN: enables stay asserted with the same operands so the responder's internal FSMs return to idle. On md_valid_i, discard the result; next state IDLE. Dropping the enables mid-operation is forbidden, because the responder would freeze in a non-idle state.
  - RESP: rsp_valid_o = 1; rsp_result_o and rsp_tag_o are stable while !rsp_ready_i. Enables are 0.
    - rsp_ready_i: req_ready_o = !flush_i (back-to-back accept). If a request is accepted, next state BUSY; otherwise IDLE.
    - flush_i: rsp_valid_o is forced 0 that cycle; next state IDLE; no accept.
- Latency from accept edge to rsp_valid_o:
  - MULL: 1 + 3 cycles.
  - MULH: 1 + 4 cycles.
  - DIV/REM: 1 + 37 cycles.
  - Divide by zero: 1 + 2 cycles.
- md_valid_i outside BUSY/DRAIN is ignored. Assertion: this must never happen.
- Watchdog:
  - Counter cleared on entry to BUSY and incremented each BUSY/DRAIN cycle.
  - When it reaches TimeoutCycles: err_o pulses for 1 cycle, the FSM forces IDLE, and any result is dropped.
  - Counter width is $clog2(TimeoutCycles+1) and saturates; it never wraps.
- At most one operation is in flight; there is no queuing.

Decomposition:
- md_op_e comes from ibex_pkg.
- Add issue_fsm_e {ISS_IDLE, ISS_BUSY, ISS_DRAIN, ISS_RESP} to ibex_pkg.
- Single module; no sub-module is warranted.
- Integration bench: instantiate ibex_multdiv_fast as the responder with the ALU adder modelled.

Test Plan:
- MULL, signed 00, a=0x0000_1234, b=0x0000_0010, tag=3, rsp_ready_i held 1 -> rsp_valid_o 4 cycles after accept, result 0x0001_2340, tag 3, single-cycle rsp_valid_o.
- MULH, signed 11, a=0xFFFF_FFFF, b=0xFFFF_FFFF -> result 0x0000_0000 after 5 cycles. Then MULH, signed 00, same operands -> result 0xFFFF_FFFE.
- DIV, signed 11, a=-7 (0xFFFF_FFF9), b=2 -> quotient 0xFFFF_FFFD. REM with the same operands -> 0xFFFF_FFFF. Each result arrives 38 cycles after accept.
- DIV with b=0 -> 0xFFFF_FFFF after 3 cycles. REM with a=0x55, b=0 -> 0x0000_0055.
- Flush 10 cycles into a DIV -> md_div_en_o stays 1 until md_valid_i, no rsp_valid_o. The next MULL, 6x7, returns 42, proving the responder is back in idle.
- Hold rsp_ready_i=0 for 5 cycles after a result -> rsp_result_o and rsp_tag_o stable and req_ready_o=0. Releasing with a new request valid -> accepted in the same cycle.
- Tie md_valid_i=0 -> err_o pulses exactly TimeoutCycles cycles after entering BUSY, the FSM returns to IDLE, and req_ready_o=1 the next cycle.
